// File: rtl/cpu_pkg.sv
// Shared CPU definitions: IR field positions, opcode values and
// the fetch-sequencer state encoding used by the fetch stage.
package cpu_pkg;

   localparam int IR_W      = 16;
   localparam int OP1_HI    = 15;
   localparam int OP1_LO    = 12;
   localparam int COND_HI   = 11;
   localparam int COND_LO   = 8;
   localparam int OP2_HI    = 7;
   localparam int OP2_LO    = 4;
   localparam int SHAMT_HI  = 3;
   localparam int SHAMT_LO  = 0;
   localparam int IMM8_HI   = 7;
   localparam int IMM8_LO   = 0;

   localparam logic [3:0] OP_RTYPE = 4'h0;
   localparam logic [3:0] OP_ANDI  = 4'h1;
   localparam logic [3:0] OP_ORI   = 4'h2;
   localparam logic [3:0] OP_XORI  = 4'h3;
   localparam logic [3:0] OP_MEM   = 4'h4;
   localparam logic [3:0] OP_ADDI  = 4'h5;
   localparam logic [3:0] OP_SHIFT = 4'h8;
   localparam logic [3:0] OP_SUBI  = 4'h9;
   localparam logic [3:0] OP_CMPI  = 4'hB;
   localparam logic [3:0] OP_BCOND = 4'hC;
   localparam logic [3:0] OP_MOVI  = 4'hD;
   localparam logic [3:0] OP_MULI  = 4'hE;
   localparam logic [3:0] OP_LUI   = 4'hF;

   typedef enum logic [1:0] {
      F_IDLE = 2'd0,
      F_WAIT = 2'd1,
      F_HOLD = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC selection: JAL > JMP > BRANCH > sequential > hold.
// Ports: pc/fetch_addr/imm8/jmp_target in, pc_d and link write-enable out.
module pc_next_logic
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic [ADDR_W-1:0] pc_i,
   input  logic [ADDR_W-1:0] fetch_addr_i,
   input  logic [7:0]        imm8_i,
   input  logic [ADDR_W-1:0] jmp_target_i,
   input  logic              pc_en_i,
   input  logic              jal_en_i,
   input  logic              jmp_en_i,
   input  logic              branch_en_i,
   input  logic              next_instr_i,
   output logic [ADDR_W-1:0] pc_d_o,
   output logic              link_we_o
);

   logic [ADDR_W-1:0] imm_sext;
   logic [ADDR_W-1:0] br_tgt;
   logic [ADDR_W-1:0] seq_pc;

   // Branch offset is relative to the branch instruction's own
   // address, not the already-incremented PC.
   assign imm_sext = {{(ADDR_W-8){imm8_i[7]}}, imm8_i};
   assign br_tgt   = fetch_addr_i + imm_sext;
   assign seq_pc   = pc_i + ADDR_W'(1);

   always_comb begin
      pc_d_o    = pc_i;
      link_we_o = 1'b0;
      if (pc_en_i) begin
         if (jal_en_i) begin
            pc_d_o    = jmp_target_i;
            link_we_o = 1'b1;
         end else if (jmp_en_i) begin
            pc_d_o = jmp_target_i;
         end else if (branch_en_i) begin
            pc_d_o = br_tgt;
         end else if (next_instr_i) begin
            pc_d_o = seq_pc;
         end
      end
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns PC and IR, sequences the multi-cycle memory read,
// decodes IR fields and applies FSM-driven PC redirects.
// Ports: FSM controls in, memory addr/data, IR + fields, pc, link_addr out.
module fetch_pc_unit
   import cpu_pkg::*;
#(
   parameter int              ADDR_W   = 16,
   parameter int              DATA_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int              MEM_LAT  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              next_instr,
   input  logic              pc_instr,
   input  logic              pc_en,
   input  logic              branch_en,
   input  logic              jmp_en,
   input  logic              jal_en,
   input  logic [ADDR_W-1:0] jmp_target,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       ir,
   output logic              instr_valid,
   output logic [3:0]        opCode1,
   output logic [3:0]        conditionCode,
   output logic [3:0]        opCode2,
   output logic [3:0]        shiftAmtIn,
   output logic [7:0]        imm8,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] link_addr
);

   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

   fetch_state_e      state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [ADDR_W-1:0] fetch_addr_q;
   logic [15:0]       ir_q;
   logic              iv_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;
   logic [ADDR_W-1:0] link_q;
   logic              link_we;

   // Fetch sequencer; IR and the valid pulse are registered here.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= F_IDLE;
         cnt_q        <= '0;
         fetch_addr_q <= RESET_PC;
         ir_q         <= 16'h0000;
         iv_q         <= 1'b0;
      end else begin
         iv_q <= 1'b0;
         unique case (state_q)
            F_IDLE: begin
               if (next_instr) begin
                  fetch_addr_q <= pc_q;
                  cnt_q        <= CNT_W'(1);
                  if (MEM_LAT == 1) begin
                     ir_q    <= mem_rdata[15:0];
                     iv_q    <= 1'b1;
                     state_q <= F_HOLD;
                  end else begin
                     state_q <= F_WAIT;
                  end
               end
            end
            F_WAIT: begin
               // Dropping next_instr abandons the read; IR keeps
               // the previous instruction.
               if (!next_instr) begin
                  state_q <= F_IDLE;
               end else if (cnt_q == CNT_LAST) begin
                  ir_q    <= mem_rdata[15:0];
                  iv_q    <= 1'b1;
                  state_q <= F_HOLD;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            F_HOLD: begin
               if (!next_instr) begin
                  state_q <= F_IDLE;
               end
            end
            default: begin
               state_q <= F_IDLE;
            end
         endcase
      end
   end

   pc_next_logic #(
      .ADDR_W (ADDR_W)
   ) u_pc_next (
      .pc_i         (pc_q),
      .fetch_addr_i (fetch_addr_q),
      .imm8_i       (ir_q[IMM8_HI:IMM8_LO]),
      .jmp_target_i (jmp_target),
      .pc_en_i      (pc_en),
      .jal_en_i     (jal_en),
      .jmp_en_i     (jmp_en),
      .branch_en_i  (branch_en),
      .next_instr_i (next_instr),
      .pc_d_o       (pc_d),
      .link_we_o    (link_we)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q   <= RESET_PC;
         link_q <= '0;
      end else begin
         pc_q <= pc_d;
         if (link_we) begin
            link_q <= pc_q;
         end
      end
   end

   // In-flight fetches keep their captured address even if the PC
   // is redirected underneath them.
   always_comb begin
      mem_addr = data_addr;
      unique case (state_q)
         F_IDLE: begin
            if (next_instr || pc_instr) begin
               mem_addr = pc_q;
            end
         end
         F_WAIT, F_HOLD: begin
            mem_addr = fetch_addr_q;
         end
         default: begin
            mem_addr = data_addr;
         end
      endcase
   end

   assign ir            = ir_q;
   assign instr_valid   = iv_q;
   assign opCode1       = ir_q[OP1_HI:OP1_LO];
   assign conditionCode = ir_q[COND_HI:COND_LO];
   assign opCode2       = ir_q[OP2_HI:OP2_LO];
   assign shiftAmtIn    = ir_q[SHAMT_HI:SHAMT_LO];
   assign imm8          = ir_q[IMM8_HI:IMM8_LO];
   assign pc            = pc_q;
   assign link_addr     = link_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: cycle table plus reset-mid-fetch.
// Memory model has a 1-cycle registered read port.
module tb_fetch_pc_unit;

   logic        clk;
   logic        reset;
   logic        next_instr;
   logic        pc_instr;
   logic        pc_en;
   logic        branch_en;
   logic        jmp_en;
   logic        jal_en;
   logic [15:0] jmp_target;
   logic [15:0] data_addr;
   logic [15:0] mem_rdata;
   logic [15:0] mem_addr;
   logic [15:0] ir;
   logic        instr_valid;
   logic [3:0]  opCode1;
   logic [3:0]  conditionCode;
   logic [3:0]  opCode2;
   logic [3:0]  shiftAmtIn;
   logic [7:0]  imm8;
   logic [15:0] pc;
   logic [15:0] link_addr;

   logic [15:0] mem [0:65535];

   int checks;
   int errors;

   fetch_pc_unit dut (
      .clk           (clk),
      .reset         (reset),
      .next_instr    (next_instr),
      .pc_instr      (pc_instr),
      .pc_en         (pc_en),
      .branch_en     (branch_en),
      .jmp_en        (jmp_en),
      .jal_en        (jal_en),
      .jmp_target    (jmp_target),
      .data_addr     (data_addr),
      .mem_rdata     (mem_rdata),
      .mem_addr      (mem_addr),
      .ir            (ir),
      .instr_valid   (instr_valid),
      .opCode1       (opCode1),
      .conditionCode (conditionCode),
      .opCode2       (opCode2),
      .shiftAmtIn    (shiftAmtIn),
      .imm8          (imm8),
      .pc            (pc),
      .link_addr     (link_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) mem_rdata <= mem[mem_addr];

   typedef struct {
      string       name;
      logic        ni, pci, pen, br, jmp, jal;
      logic [15:0] tgt;
      logic        poke;
      logic [15:0] pa, pd;
      logic [15:0] e_maddr, e_pc, e_ir;
      logic        e_iv;
      logic [15:0] e_link;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(
      string n, logic ni, logic pci, logic pen, logic br,
      logic jmp, logic jal, logic [15:0] tgt,
      logic poke, logic [15:0] pa, logic [15:0] pd,
      logic [15:0] ema, logic [15:0] epc, logic [15:0] eir,
      logic eiv, logic [15:0] elk);
      vec_t v;
      v.name = n; v.ni = ni; v.pci = pci; v.pen = pen;
      v.br = br; v.jmp = jmp; v.jal = jal; v.tgt = tgt;
      v.poke = poke; v.pa = pa; v.pd = pd;
      v.e_maddr = ema; v.e_pc = epc; v.e_ir = eir;
      v.e_iv = eiv; v.e_link = elk;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      next_instr = 0; pc_instr = 0; pc_en = 0;
      branch_en = 0; jmp_en = 0; jal_en = 0;
      jmp_target = 16'h0000;
   endtask

   task automatic chk_state(input string nm, input logic [15:0] epc,
                            input logic [15:0] eir, input logic eiv,
                            input logic [15:0] elk);
      logic [15:0] e;
      e = eir;
      chk({nm, ".pc"}, pc, epc);
      chk({nm, ".ir"}, ir, e);
      chk({nm, ".iv"}, {15'd0, instr_valid}, {15'd0, eiv});
      chk({nm, ".link"}, link_addr, elk);
      chk({nm, ".op1"}, {12'd0, opCode1}, {12'd0, e[15:12]});
      chk({nm, ".cc"}, {12'd0, conditionCode}, {12'd0, e[11:8]});
      chk({nm, ".op2"}, {12'd0, opCode2}, {12'd0, e[7:4]});
      chk({nm, ".sh"}, {12'd0, shiftAmtIn}, {12'd0, e[3:0]});
      chk({nm, ".imm8"}, {8'd0, imm8}, {8'd0, e[7:0]});
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
      mem[16'h0000] = 16'h5A03;
      mem[16'h0010] = 16'h70FC;
      mem[16'hFFFF] = 16'h1234;

      // name ni pci pen br jmp jal tgt poke pa pd | maddr pc ir iv link
      vq.push_back(mk("idle",      0,0,0,0,0,0,16'h0000,0,0,0, 16'h0ABC,16'h0000,16'h0000,0,16'h0000));
      vq.push_back(mk("fetch0",    1,0,0,0,0,0,16'h0000,0,0,0, 16'h0000,16'h0000,16'h0000,0,16'h0000));
      vq.push_back(mk("fetch2_0",  1,0,1,0,0,0,16'h0000,0,0,0, 16'h0000,16'h0001,16'h5A03,1,16'h0000));
      vq.push_back(mk("drop0",     0,0,0,0,0,0,16'h0000,0,0,0, 16'h0000,16'h0001,16'h5A03,0,16'h0000));
      vq.push_back(mk("pcinstr",   0,1,0,0,0,0,16'h0000,0,0,0, 16'h0001,16'h0001,16'h5A03,0,16'h0000));
      vq.push_back(mk("jmp10",     0,0,1,0,1,0,16'h0010,0,0,0, 16'h0ABC,16'h0010,16'h5A03,0,16'h0000));
      vq.push_back(mk("fetch10",   1,0,0,0,0,0,16'h0000,0,0,0, 16'h0010,16'h0010,16'h5A03,0,16'h0000));
      vq.push_back(mk("fetch2_10", 1,0,1,0,0,0,16'h0000,0,0,0, 16'h0010,16'h0011,16'h70FC,1,16'h0000));
      vq.push_back(mk("hold10",    1,0,0,0,0,0,16'h0000,0,0,0, 16'h0010,16'h0011,16'h70FC,0,16'h0000));
      vq.push_back(mk("br_m4",     0,0,1,1,0,0,16'h0000,0,0,0, 16'h0010,16'h000C,16'h70FC,0,16'h0000));
      vq.push_back(mk("pen_only",  0,0,1,0,0,0,16'h0000,0,0,0, 16'h0ABC,16'h000C,16'h70FC,0,16'h0000));
      vq.push_back(mk("rejmp10",   0,0,1,0,1,0,16'h0010,1,16'h0010,16'h7005, 16'h0ABC,16'h0010,16'h70FC,0,16'h0000));
      vq.push_back(mk("refetch10", 1,0,0,0,0,0,16'h0000,0,0,0, 16'h0010,16'h0010,16'h70FC,0,16'h0000));
      vq.push_back(mk("refetch2",  1,0,1,0,0,0,16'h0000,0,0,0, 16'h0010,16'h0011,16'h7005,1,16'h0000));
      vq.push_back(mk("br_p5",     0,0,1,1,0,0,16'h0000,0,0,0, 16'h0010,16'h0015,16'h7005,0,16'h0000));
      vq.push_back(mk("jmp_vs_br", 0,0,1,1,1,0,16'h0100,0,0,0, 16'h0ABC,16'h0100,16'h7005,0,16'h0000));
      vq.push_back(mk("jmp21",     0,0,1,0,1,0,16'h0021,0,0,0, 16'h0ABC,16'h0021,16'h7005,0,16'h0000));
      vq.push_back(mk("jal",       0,0,1,1,0,1,16'h0200,0,0,0, 16'h0ABC,16'h0200,16'h7005,0,16'h0021));
      vq.push_back(mk("jmpFFFF",   0,0,1,0,1,0,16'hFFFF,0,0,0, 16'h0ABC,16'hFFFF,16'h7005,0,16'h0021));
      vq.push_back(mk("fetchFFFF", 1,0,0,0,0,0,16'h0000,0,0,0, 16'hFFFF,16'hFFFF,16'h7005,0,16'h0021));
      vq.push_back(mk("fetch2FF",  1,0,1,0,0,0,16'h0000,0,0,0, 16'hFFFF,16'h0000,16'h1234,1,16'h0021));
      vq.push_back(mk("dropFFFF",  0,0,0,0,0,0,16'h0000,0,0,0, 16'hFFFF,16'h0000,16'h1234,0,16'h0021));
      vq.push_back(mk("br_wrap",   0,0,1,1,0,0,16'h0000,0,0,0, 16'h0ABC,16'h0033,16'h1234,0,16'h0021));
      vq.push_back(mk("abort_a",   1,0,0,0,0,0,16'h0000,1,16'h0033,16'hBEEF, 16'h0033,16'h0033,16'h1234,0,16'h0021));
      vq.push_back(mk("abort_b",   0,0,0,0,0,0,16'h0000,0,0,0, 16'h0033,16'h0033,16'h1234,0,16'h0021));
      vq.push_back(mk("abort_c",   0,0,0,0,0,0,16'h0000,0,0,0, 16'h0ABC,16'h0033,16'h1234,0,16'h0021));
      vq.push_back(mk("fw_a",      1,0,0,0,0,0,16'h0000,0,0,0, 16'h0033,16'h0033,16'h1234,0,16'h0021));
      vq.push_back(mk("fw_b",      1,0,1,0,1,0,16'h0300,0,0,0, 16'h0033,16'h0300,16'hBEEF,1,16'h0021));
      vq.push_back(mk("fw_c",      0,0,0,0,0,0,16'h0000,0,0,0, 16'h0033,16'h0300,16'hBEEF,0,16'h0021));

      idle_inputs();
      data_addr = 16'h0ABC;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_state("reset", 16'h0000, 16'h0000, 1'b0, 16'h0000);
      @(negedge clk);
      reset = 1'b1;

      foreach (vq[i]) begin
         @(negedge clk);
         if (vq[i].poke) mem[vq[i].pa] = vq[i].pd;
         next_instr = vq[i].ni;
         pc_instr   = vq[i].pci;
         pc_en      = vq[i].pen;
         branch_en  = vq[i].br;
         jmp_en     = vq[i].jmp;
         jal_en     = vq[i].jal;
         jmp_target = vq[i].tgt;
         #1;
         chk({vq[i].name, ".maddr"}, mem_addr, vq[i].e_maddr);
         @(posedge clk);
         #1;
         chk_state(vq[i].name, vq[i].e_pc, vq[i].e_ir,
                   vq[i].e_iv, vq[i].e_link);
      end

      // Reset asserted while a fetch is in flight.
      @(negedge clk);
      idle_inputs();
      next_instr = 1;
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk_state("rst_mid", 16'h0000, 16'h0000, 1'b0, 16'h0000);
      chk("rst_mid.maddr", mem_addr, 16'h0000);
      @(posedge clk);
      #1;
      chk_state("rst_hold", 16'h0000, 16'h0000, 1'b0, 16'h0000);
      @(negedge clk);
      next_instr = 0;
      reset = 1'b1;
      @(negedge clk);
      next_instr = 1;
      #1;
      chk("rf_fetch.maddr", mem_addr, 16'h0000);
      @(posedge clk);
      #1;
      chk_state("rf_fetch", 16'h0000, 16'h0000, 1'b0, 16'h0000);
      @(negedge clk);
      pc_en = 1;
      #1;
      chk("rf_fetch2.maddr", mem_addr, 16'h0000);
      @(posedge clk);
      #1;
      chk_state("rf_fetch2", 16'h0001, 16'h5A03, 1'b1, 16'h0000);
      @(negedge clk);
      idle_inputs();
      @(posedge clk);
      #1;
      chk_state("rf_after", 16'h0001, 16'h5A03, 1'b0, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
